// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage defaults and fetch state encoding
package cpu_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0;
    typedef enum logic {RUN, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: sync FIFO with flush whose head output holds its last value while empty
module fetch_queue #(
    parameter int W = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] held;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_pop;
    assign do_pop = pop && count != '0;
    assign dout = count != '0 ? mem[rd_ptr] : held;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            held <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            held <= dout;
        end else begin
            held <= dout;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(do_pop);
        end
    always_ff @(posedge clock)
        if (push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC request issue, in-order prefetch queue and redirect drain for the IF stage
module fetch_prefetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc4,
    output logic [ADDR_W-1:0] pc_out
);
    localparam int CW = $clog2(DEPTH) + 1;
    fetch_state_t state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc, tag_pc;
    logic [DATA_W+ADDR_W-1:0] head;
    logic [CW-1:0] count, outstanding, stale, stale_nxt;
    logic accept, enq, pop;
    assign imem_req_valid = reset && state == RUN && !redirect && count + outstanding < CW'(DEPTH);
    assign accept = imem_req_valid && imem_req_ready;
    assign enq = imem_rsp_valid && stale == '0 && !redirect;
    assign pop = id_valid && id_ready && !redirect;
    assign id_valid = count != '0;
    assign {id_instr, id_pc4} = head;
    assign imem_req_addr = fetch_pc;
    assign pc_out = fetch_pc;
    // tag FIFO occupancy is the outstanding-request count; it is never flushed so stale tags retire
    fetch_queue #(.W(ADDR_W), .DEPTH(DEPTH)) u_tag (
        .clock, .reset, .flush(1'b0), .push(accept), .din(fetch_pc),
        .pop(imem_rsp_valid), .dout(tag_pc), .count(outstanding)
    );
    fetch_queue #(.W(DATA_W + ADDR_W), .DEPTH(DEPTH)) u_queue (
        .clock, .reset, .flush(redirect), .push(enq), .din({imem_rsp_data, tag_pc + ADDR_W'(4)}),
        .pop, .dout(head), .count
    );
    always_comb begin
        stale_nxt = redirect ? outstanding - CW'(imem_rsp_valid) : stale - CW'(imem_rsp_valid && stale != '0);
        state_nxt = stale_nxt != '0 ? DRAIN : RUN;
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state <= RUN;
            stale <= '0;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            stale <= stale_nxt;
            fetch_pc <= redirect ? redirect_pc : accept ? fetch_pc + ADDR_W'(4) : fetch_pc;
        end
endmodule
